// File: rtl/regfile_wb_stage.sv
// regfile_wb_stage: write-back stage register in front of an NREG x DATA_W
// general register file.
//
// A write-back request {addr, data, we} is captured into a pending slot on a
// rising edge. It is committed to the array on the following edge. Both read
// ports bypass from the pending slot, so a captured value is readable right
// after its capture edge. Register 0 always reads as zero.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   wb_valid_i, wb_we_i   slot holds a real instruction / instruction writes a reg
//   wb_addr_i, wb_data_i  destination register (from the rt/rd mux) and data
//   stall_i               do not capture this cycle; insert a bubble
//   flush_i               discard the input and clear the pending write
//   rs_addr_i, rt_addr_i  read port A / B addresses
//   rs_data_o, rt_data_o  read port A / B data (combinational)
//   wb_pending_o          a captured write is waiting to commit
//   wb_paddr_o            address of the pending write, 0 when none is pending
module regfile_wb_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREG   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic              wb_pending_o,
  output logic [ADDR_W-1:0] wb_paddr_o
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } pend_t;

  pend_t             pend_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] regs [NREG];

  logic              cap_ok_c;

  // A write qualifies only if it is real, enables a write and does not target r0.
  assign cap_ok_c = wb_valid_i & wb_we_i & (wb_addr_i != '0);

  // Register array: commits the pending write on every edge, regardless of stall/flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
    end else if (pend_q.valid) begin
      regs[pend_q.addr] <= pend_q.data;
    end
  end

  // Pending slot capture, priority flush > stall > normal.
  // During a stall addr/data hold, but the slot is emptied (bubble).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else if (flush_i) begin
      pend_q.valid <= 1'b0;
      pend_q.addr  <= '0;
    end else if (stall_i) begin
      pend_q.valid <= 1'b0;
    end else begin
      pend_q.valid <= cap_ok_c;
      pend_q.addr  <= cap_ok_c ? wb_addr_i : '0;
      pend_q.data  <= wb_data_i;
    end
  end

  // Hazard-visible pending address: registered separately so it reads 0
  // whenever nothing is pending, even while pend_q.addr holds across a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paddr_q <= '0;
    end else if (flush_i || stall_i || !cap_ok_c) begin
      paddr_q <= '0;
    end else begin
      paddr_q <= wb_addr_i;
    end
  end

  // Read port A with bypass from the pending write.
  always_comb begin
    rs_data_o = '0;
    if (rs_addr_i != '0) begin
      if (pend_q.valid && (pend_q.addr == rs_addr_i)) begin
        rs_data_o = pend_q.data;
      end else begin
        rs_data_o = regs[rs_addr_i];
      end
    end
  end

  // Read port B, identical to port A.
  always_comb begin
    rt_data_o = '0;
    if (rt_addr_i != '0) begin
      if (pend_q.valid && (pend_q.addr == rt_addr_i)) begin
        rt_data_o = pend_q.data;
      end else begin
        rt_data_o = regs[rt_addr_i];
      end
    end
  end

  assign wb_pending_o = pend_q.valid;
  assign wb_paddr_o   = paddr_q;

endmodule

// File: tb/tb_regfile_wb_stage.sv
// Scoreboard bench for regfile_wb_stage. The reference model keeps only the
// architectural view: a register is considered updated at its capture edge,
// because the bypass makes the pending value visible immediately and a
// captured write always commits unless reset intervenes.
module tb_regfile_wb_stage;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREG   = 32;

  logic              clk;
  logic              rst_n;
  logic              wb_valid_i;
  logic              wb_we_i;
  logic [ADDR_W-1:0] wb_addr_i;
  logic [DATA_W-1:0] wb_data_i;
  logic              stall_i;
  logic              flush_i;
  logic [ADDR_W-1:0] rs_addr_i;
  logic [ADDR_W-1:0] rt_addr_i;
  logic [DATA_W-1:0] rs_data_o;
  logic [DATA_W-1:0] rt_data_o;
  logic              wb_pending_o;
  logic [ADDR_W-1:0] wb_paddr_o;

  regfile_wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_valid_i   (wb_valid_i),
    .wb_we_i      (wb_we_i),
    .wb_addr_i    (wb_addr_i),
    .wb_data_i    (wb_data_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .rs_addr_i    (rs_addr_i),
    .rt_addr_i    (rt_addr_i),
    .rs_data_o    (rs_data_o),
    .rt_data_o    (rt_data_o),
    .wb_pending_o (wb_pending_o),
    .wb_paddr_o   (wb_paddr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
    logic              pend;
    logic [ADDR_W-1:0] paddr;
    string             tag;
  } exp_t;

  exp_t q[$];

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [DATA_W-1:0] arch [NREG];
  logic              m_pend;
  logic [ADDR_W-1:0] m_paddr;

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] m_read(input logic [ADDR_W-1:0] a);
    return (a == '0) ? '0 : arch[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < int'(NREG); i++) arch[i] = '0;
    m_pend  = 1'b0;
    m_paddr = '0;
  endtask

  // Monitor: outputs are always presented; compare once per cycle at negedge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.tag, " rs"},    rs_data_o, e.rs);
      chk({e.tag, " rt"},    rt_data_o, e.rt);
      chk({e.tag, " pend"},  DATA_W'(wb_pending_o), DATA_W'(e.pend));
      chk({e.tag, " paddr"}, DATA_W'(wb_paddr_o),   DATA_W'(e.paddr));
    end
  end

  // One cycle, entered at posedge+1: drive, queue expectation, take the edge, update model.
  task automatic cyc(input string tag, input logic v, input logic we,
                     input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                     input logic st, input logic fl,
                     input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt);
    exp_t e;
    wb_valid_i = v; wb_we_i = we; wb_addr_i = a; wb_data_i = d;
    stall_i = st; flush_i = fl; rs_addr_i = rs; rt_addr_i = rt;
    e.rs = m_read(rs); e.rt = m_read(rt); e.pend = m_pend; e.paddr = m_paddr; e.tag = tag;
    q.push_back(e);
    @(posedge clk);
    if (!fl && !st && v && we && (a != '0)) begin
      arch[a] = d;
      m_pend  = 1'b1;
      m_paddr = a;
    end else begin
      m_pend  = 1'b0;
      m_paddr = '0;
    end
    #1;
  endtask

  task automatic idle(input string tag, input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt);
    cyc(tag, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, rs, rt);
  endtask

  initial begin
    logic [ADDR_W-1:0] last_a;
    m_reset();
    rst_n = 1'b0;
    wb_valid_i = 0; wb_we_i = 0; wb_addr_i = '0; wb_data_i = '0;
    stall_i = 0; flush_i = 0; rs_addr_i = 5'd5; rt_addr_i = 5'd31;
    #3;
    chk("reset rs",    rs_data_o, '0);
    chk("reset rt",    rt_data_o, '0);
    chk("reset pend",  DATA_W'(wb_pending_o), '0);
    chk("reset paddr", DATA_W'(wb_paddr_o), '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // T1 write / bypass / commit
    cyc("t1 cap", 1, 1, 5'd5, 32'hDEADBEEF, 0, 0, 5'd5, 5'd5);
    idle("t1 bypass", 5'd5, 5'd0);
    idle("t1 commit", 5'd5, 5'd5);

    // T2 register 0
    cyc("t2 cap", 1, 1, 5'd0, 32'h12345678, 0, 0, 5'd0, 5'd0);
    idle("t2 a", 5'd0, 5'd0);
    idle("t2 b", 5'd0, 5'd0);

    // T3 back-to-back to one address
    cyc("t3 w1", 1, 1, 5'd7, 32'h1, 0, 0, 5'd7, 5'd7);
    cyc("t3 w2", 1, 1, 5'd7, 32'h2, 0, 0, 5'd7, 5'd7);
    idle("t3 pend", 5'd7, 5'd7);
    idle("t3 array", 5'd7, 5'd7);

    // T4 flush
    cyc("t4 cap", 1, 1, 5'd9, 32'hAA, 0, 0, 5'd9, 5'd10);
    cyc("t4 flush", 1, 1, 5'd10, 32'hBB, 0, 1, 5'd9, 5'd10);
    idle("t4 after", 5'd9, 5'd10);
    idle("t4 after2", 5'd9, 5'd10);

    // T5 stall with held input, then release
    cyc("t5 st1", 1, 1, 5'd3, 32'h55, 1, 0, 5'd3, 5'd3);
    cyc("t5 st2", 1, 1, 5'd3, 32'h55, 1, 0, 5'd3, 5'd3);
    cyc("t5 st3", 1, 1, 5'd3, 32'h55, 1, 0, 5'd3, 5'd3);
    cyc("t5 go", 1, 1, 5'd3, 32'h55, 0, 0, 5'd3, 5'd3);
    idle("t5 pend", 5'd3, 5'd3);
    idle("t5 array", 5'd3, 5'd3);

    // T6 asynchronous reset with a write pending
    cyc("t6 cap", 1, 1, 5'd4, 32'h77, 0, 0, 5'd4, 5'd5);
    idle("t6 pre", 5'd4, 5'd5);
    wb_valid_i = 0; rs_addr_i = 5'd4; rt_addr_i = 5'd5;
    cyc("t6 cap2", 1, 1, 5'd4, 32'h99, 0, 0, 5'd4, 5'd5);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t6 async rs",    rs_data_o, '0);
    chk("t6 async rt",    rt_data_o, '0);
    chk("t6 async pend",  DATA_W'(wb_pending_o), '0);
    chk("t6 async paddr", DATA_W'(wb_paddr_o), '0);
    m_reset();
    wb_valid_i = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    idle("t6 post", 5'd4, 5'd5);
    idle("t6 post2", 5'd4, 5'd5);

    // Randomized traffic, reads biased toward the most recent write address
    last_a = 5'd1;
    for (int n = 0; n < 3000; n++) begin
      logic [ADDR_W-1:0] a, rs, rt;
      logic v, we, st, fl;
      a  = ($urandom_range(0, 3) == 0) ? last_a : ADDR_W'($urandom);
      v  = ($urandom_range(0, 7) != 0);
      we = ($urandom_range(0, 5) != 0);
      st = ($urandom_range(0, 9) == 0);
      fl = ($urandom_range(0, 14) == 0);
      rs = ($urandom_range(0, 1) == 0) ? last_a : ADDR_W'($urandom);
      rt = ($urandom_range(0, 2) == 0) ? a : ADDR_W'($urandom);
      cyc("rand", v, we, a, DATA_W'($urandom), st, fl, rs, rt);
      if (v && we && !st && !fl && a != '0) last_a = a;
    end
    idle("drain", 5'd1, 5'd2);

    @(negedge clk); #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
